// File: rtl/fft_ctrl_if.sv
// rtl/fft_ctrl_if.sv - butterfly operand/write-back bus between the FFT controller and its datapath
interface fft_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    localparam int SW = $clog2(ADDR_WIDTH) + 1;

    logic                  start;
    logic                  bf_ready;
    logic                  bf_valid;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [ADDR_WIDTH-1:0] tw_addr;
    logic [SW-1:0]         stage;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr_a;
    logic [ADDR_WIDTH-1:0] wr_addr_b;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, bf_ready,
        output bf_valid, rd_addr_a, rd_addr_b, tw_addr, stage,
        output wr_en, wr_addr_a, wr_addr_b, busy, done
    );

    modport slave (
        output start, bf_ready,
        input  bf_valid, rd_addr_a, rd_addr_b, tw_addr, stage,
        input  wr_en, wr_addr_a, wr_addr_b, busy, done
    );
endinterface

// File: rtl/fft_ctrl.sv
// rtl/fft_ctrl.sv - radix-2 DIT FFT sequencer: butterfly address generation, stage drain and write-back timing
module fft_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int PIPE_LAT   = 2
) (
    input  logic      clk,
    input  logic      rst,
    fft_ctrl_if.master bus
);
    localparam int N    = 1 << ADDR_WIDTH;
    localparam int S    = ADDR_WIDTH;
    localparam int HALF = N / 2;
    localparam int SW   = $clog2(S) + 1;
    localparam int AW   = ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    logic [SW-1:0] stage_q;
    logic [AW-1:0] k;
    logic [3:0]    drain_cnt;
    logic          bf_valid_q;
    logic          busy_q;
    logic          done_q;
    logic [AW-1:0] rd_a_q;
    logic [AW-1:0] rd_b_q;
    logic [AW-1:0] tw_q;

    logic          pipe_v [PIPE_LAT];
    logic [AW-1:0] pipe_a [PIPE_LAT];
    logic [AW-1:0] pipe_b [PIPE_LAT];

    logic accept;

    // Top operand: group base (grp * 2 * span) plus position inside the group.
    function automatic logic [AW-1:0] calc_a(input logic [SW-1:0] s, input logic [AW-1:0] kk);
        int sh;
        logic [AW-1:0] mask;
        sh   = int'(s);
        mask = (AW'(1) << sh) - AW'(1);
        return ((kk >> sh) << (sh + 1)) | (kk & mask);
    endfunction

    // Bottom operand sits one span above the top operand.
    function automatic logic [AW-1:0] calc_b(input logic [SW-1:0] s, input logic [AW-1:0] kk);
        return calc_a(s, kk) + (AW'(1) << int'(s));
    endfunction

    // Twiddle index: position within the group scaled to the N-point ROM.
    function automatic logic [AW-1:0] calc_tw(input logic [SW-1:0] s, input logic [AW-1:0] kk);
        int sh;
        logic [AW-1:0] mask;
        sh   = int'(s);
        mask = (AW'(1) << sh) - AW'(1);
        return (kk & mask) << (S - 1 - sh);
    endfunction

    assign accept = bf_valid_q && bus.bf_ready;

    // Sequencer FSM; address outputs are registered for the next butterfly presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stage_q    <= '0;
            k          <= '0;
            drain_cnt  <= '0;
            bf_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            tw_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state      <= RUN;
                        stage_q    <= '0;
                        k          <= '0;
                        bf_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        rd_a_q     <= calc_a('0, '0);
                        rd_b_q     <= calc_b('0, '0);
                        tw_q       <= calc_tw('0, '0);
                    end
                end
                RUN: begin
                    if (bus.bf_ready) begin
                        if (k == AW'(HALF - 1)) begin
                            state      <= DRAIN;
                            drain_cnt  <= '0;
                            bf_valid_q <= 1'b0;
                        end else begin
                            k      <= k + 1'b1;
                            rd_a_q <= calc_a(stage_q, k + 1'b1);
                            rd_b_q <= calc_b(stage_q, k + 1'b1);
                            tw_q   <= calc_tw(stage_q, k + 1'b1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'(PIPE_LAT - 1)) begin
                        if (stage_q == SW'(S - 1)) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state      <= RUN;
                            stage_q    <= stage_q + 1'b1;
                            k          <= '0;
                            bf_valid_q <= 1'b1;
                            rd_a_q     <= calc_a(stage_q + 1'b1, '0);
                            rd_b_q     <= calc_b(stage_q + 1'b1, '0);
                            tw_q       <= calc_tw(stage_q + 1'b1, '0);
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back delay line mirroring the butterfly datapath latency; flushed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else begin
            pipe_v[0] <= accept;
            pipe_a[0] <= rd_a_q;
            pipe_b[0] <= rd_b_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

    assign bus.bf_valid  = bf_valid_q;
    assign bus.rd_addr_a = rd_a_q;
    assign bus.rd_addr_b = rd_b_q;
    assign bus.tw_addr   = tw_q;
    assign bus.stage     = stage_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_en     = pipe_v[PIPE_LAT-1];
    assign bus.wr_addr_a = pipe_a[PIPE_LAT-1];
    assign bus.wr_addr_b = pipe_b[PIPE_LAT-1];
endmodule

// File: tb/tb_fft_ctrl.sv
// tb/tb_fft_ctrl.sv - self-checking bench for fft_ctrl
module tb_fft_ctrl;
    localparam int AW = 4;
    localparam int PL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_ctrl_if #(.ADDR_WIDTH(AW)) ifm ();
    fft_ctrl_if #(.ADDR_WIDTH(AW)) if1 ();
    fft_ctrl_if #(.ADDR_WIDTH(AW)) if8 ();

    fft_ctrl #(.ADDR_WIDTH(AW), .PIPE_LAT(PL)) dut (.clk(clk), .rst(rst), .bus(ifm.master));
    fft_ctrl #(.ADDR_WIDTH(AW), .PIPE_LAT(1))  u1  (.clk(clk), .rst(rst), .bus(if1.master));
    fft_ctrl #(.ADDR_WIDTH(AW), .PIPE_LAT(8))  u8  (.clk(clk), .rst(rst), .bus(if8.master));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; int a; int b; int s; } wr_t;
    typedef struct { int s; int k; int a; int b; int tw; } vec_t;

    wr_t        q[$];
    vec_t       tbl[10];
    int         m_s, m_k;
    logic [15:0] wmask[4];
    int         obs_a[4][8], obs_b[4][8], obs_tw[4][8];
    int         busy_cnt, first_busy, last_busy, done_cnt, done_cyc, wr_cnt;
    logic       stall_prev;
    int         prev_abt;
    int         x_busy[2], x_drain[2], x_wr[2], x_done[2], x_done_cyc[2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mdl_a(input int s, input int kk);
        int span;
        span = 1 << s;
        return (kk / span) * 2 * span + (kk % span);
    endfunction

    function automatic int mdl_tw(input int s, input int kk);
        return (kk % (1 << s)) * (1 << (AW - 1 - s));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        busy_cnt = 0; first_busy = -1; last_busy = -1;
        done_cnt = 0; done_cyc = -1; wr_cnt = 0;
        for (int s = 0; s < 4; s++) wmask[s] = '0;
        for (int j = 0; j < 2; j++) begin
            x_busy[j] = 0; x_drain[j] = 0; x_wr[j] = 0; x_done[j] = 0; x_done_cyc[j] = -1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifm.start = 1'b0; if1.start = 1'b0; if8.start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard monitor for the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_s = 0;
            m_k = 0;
            stall_prev = 1'b0;
        end else begin
            if (ifm.busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
            end
            if (ifm.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stall_prev && ifm.bf_valid)
                chk("stall_hold", {ifm.rd_addr_a, ifm.rd_addr_b, ifm.tw_addr, ifm.stage}, prev_abt);
            if (ifm.wr_en) begin
                wr_t e;
                wr_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_wr_en", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("wr_cycle", cyc, e.due);
                    chk("wr_addr_a", int'(ifm.wr_addr_a), e.a);
                    chk("wr_addr_b", int'(ifm.wr_addr_b), e.b);
                    if (wmask[e.s][ifm.wr_addr_a] || wmask[e.s][ifm.wr_addr_b])
                        chk("dup_write", 1, 0);
                    wmask[e.s][ifm.wr_addr_a] = 1'b1;
                    wmask[e.s][ifm.wr_addr_b] = 1'b1;
                end
            end
            if (ifm.bf_valid && ifm.bf_ready) begin
                if (m_s < 4) begin
                    chk("rd_addr_a", int'(ifm.rd_addr_a), mdl_a(m_s, m_k));
                    chk("rd_addr_b", int'(ifm.rd_addr_b), mdl_a(m_s, m_k) + (1 << m_s));
                    chk("tw_addr", int'(ifm.tw_addr), mdl_tw(m_s, m_k));
                    chk("stage", int'(ifm.stage), m_s);
                    obs_a[m_s][m_k]  = int'(ifm.rd_addr_a);
                    obs_b[m_s][m_k]  = int'(ifm.rd_addr_b);
                    obs_tw[m_s][m_k] = int'(ifm.tw_addr);
                    q.push_back('{cyc + PL, int'(ifm.rd_addr_a), int'(ifm.rd_addr_b), m_s});
                end else begin
                    chk("accept_after_last_stage", 1, 0);
                end
                m_k++;
                if (m_k == 8) begin
                    m_k = 0;
                    m_s++;
                end
            end
            stall_prev = ifm.bf_valid && !ifm.bf_ready;
            prev_abt = {ifm.rd_addr_a, ifm.rd_addr_b, ifm.tw_addr, ifm.stage};
        end
    end

    // Activity counters for the PIPE_LAT=1 and PIPE_LAT=8 instances.
    always @(negedge clk) begin
        if (!rst) begin
            if (if1.busy) x_busy[0]++;
            if (if1.busy && !if1.bf_valid) x_drain[0]++;
            if (if1.wr_en) x_wr[0]++;
            if (if1.done) begin x_done[0]++; x_done_cyc[0] = cyc; end
            if (if8.busy) x_busy[1]++;
            if (if8.busy && !if8.bf_valid) x_drain[1]++;
            if (if8.wr_en) x_wr[1]++;
            if (if8.done) begin x_done[1]++; x_done_cyc[1] = cyc; end
        end
    end

    // mode 0: bf_ready held high; 1: random bf_ready; 2: stray start pulses during RUN, DRAIN and DONE
    task automatic run_full(input int mode, input int budget);
        int s0, post, rel;
        clear_stats();
        ifm.bf_ready = 1'b1;
        ifm.start = 1'b1;
        s0 = cyc;
        post = 0;
        for (int i = 0; i < budget && post < 10; i++) begin
            tick();
            rel = cyc - s0;
            ifm.start = (mode == 2) && (rel == 5 || rel == 9 || rel == 41);
            ifm.bf_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done_cnt > 0) post++;
        end
        ifm.start = 1'b0;
        ifm.bf_ready = 1'b1;
        chk("done_pulses", done_cnt, 1);
        chk("wr_en_pulses", wr_cnt, 32);
        chk("queue_empty", q.size(), 0);
        if (mode != 1) begin
            chk("busy_cycles", busy_cnt, 40);
            chk("first_busy", first_busy - s0, 1);
            chk("last_busy", last_busy - s0, 40);
            chk("done_cycle", done_cyc - s0, 41);
        end else begin
            chk("busy_contiguous", busy_cnt, done_cyc - first_busy);
        end
        for (int s = 0; s < 4; s++) chk($sformatf("stage%0d_coverage", s), int'(wmask[s]), 16'hFFFF);
        chk("idle_busy", int'(ifm.busy), 0);
        chk("idle_bf_valid", int'(ifm.bf_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 0, 0, 1, 0};
        tbl[1] = '{1, 1, 1, 3, 4};
        tbl[2] = '{2, 5, 9, 13, 2};
        tbl[3] = '{3, 3, 3, 11, 3};
        tbl[4] = '{0, 7, 14, 15, 0};
        tbl[5] = '{3, 7, 7, 15, 7};
        tbl[6] = '{1, 6, 12, 14, 0};
        tbl[7] = '{2, 3, 3, 7, 6};
        tbl[8] = '{1, 5, 9, 11, 4};
        tbl[9] = '{2, 0, 0, 4, 0};

        ifm.start = 1'b0; ifm.bf_ready = 1'b1;
        if1.start = 1'b0; if1.bf_ready = 1'b1;
        if8.start = 1'b0; if8.bf_ready = 1'b1;
        clear_stats();
        do_reset();

        chk("rst_bf_valid", int'(ifm.bf_valid), 0);
        chk("rst_wr_en", int'(ifm.wr_en), 0);
        chk("rst_busy", int'(ifm.busy), 0);
        chk("rst_done", int'(ifm.done), 0);
        chk("rst_stage", int'(ifm.stage), 0);
        chk("rst_addrs", {ifm.rd_addr_a, ifm.rd_addr_b, ifm.tw_addr, ifm.wr_addr_a, ifm.wr_addr_b}, 0);

        run_full(0, 100);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl%0d_a", i), obs_a[tbl[i].s][tbl[i].k], tbl[i].a);
            chk($sformatf("tbl%0d_b", i), obs_b[tbl[i].s][tbl[i].k], tbl[i].b);
            chk($sformatf("tbl%0d_tw", i), obs_tw[tbl[i].s][tbl[i].k], tbl[i].tw);
        end

        do_reset();
        run_full(1, 600);

        do_reset();
        run_full(2, 100);

        // Reset in the middle of stage 2, while earlier butterflies are still in flight.
        begin
            int found, wr_before;
            do_reset();
            clear_stats();
            ifm.start = 1'b1;
            found = 0;
            for (int i = 0; i < 100 && found == 0; i++) begin
                tick();
                ifm.start = 1'b0;
                if (ifm.bf_valid && ifm.stage == 2 && ifm.rd_addr_a == 4'd8) found = 1;
            end
            chk("reached_s2_k4", found, 1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("mid_rst_bf_valid", int'(ifm.bf_valid), 0);
            chk("mid_rst_wr_en", int'(ifm.wr_en), 0);
            chk("mid_rst_busy", int'(ifm.busy), 0);
            chk("mid_rst_done", int'(ifm.done), 0);
            chk("mid_rst_stage", int'(ifm.stage), 0);
            chk("mid_rst_addrs", {ifm.rd_addr_a, ifm.rd_addr_b, ifm.tw_addr, ifm.wr_addr_a, ifm.wr_addr_b}, 0);
            wr_before = wr_cnt;
            repeat (20) tick();
            chk("no_wr_after_rst", wr_cnt - wr_before, 0);
            chk("idle_after_rst", int'(ifm.busy), 0);
            run_full(0, 100);
        end

        // Drain length scaling for the other pipeline latencies.
        begin
            int s0;
            do_reset();
            clear_stats();
            if1.start = 1'b1;
            if8.start = 1'b1;
            s0 = cyc;
            tick();
            if1.start = 1'b0;
            if8.start = 1'b0;
            for (int i = 0; i < 200 && (x_done[0] == 0 || x_done[1] == 0); i++) tick();
            repeat (5) tick();
            chk("pl1_busy", x_busy[0], 36);
            chk("pl1_drain", x_drain[0], 4);
            chk("pl1_done_cycle", x_done_cyc[0] - s0, 37);
            chk("pl1_wr_en", x_wr[0], 32);
            chk("pl8_busy", x_busy[1], 64);
            chk("pl8_drain", x_drain[1], 32);
            chk("pl8_done_cycle", x_done_cyc[1] - s0, 65);
            chk("pl8_wr_en", x_wr[1], 32);
            chk("pl8_done_pulses", x_done[1], 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, log2 of FFT size N; N = 2**ADDR_WIDTH; stages S = ADDR_WIDTH.
REQ-002 Parameter PIPE_LAT, default 2, butterfly datapath latency in cycles; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to run a full FFT; sampled only in IDLE.
REQ-006 bf_ready  input  1  butterfly datapath accepts the presented operand pair this cycle.
REQ-007 bf_valid  output  1  operand read addresses and twiddle address are valid.
REQ-008 rd_addr_a, rd_addr_b  output  ADDR_WIDTH  data-memory read addresses of butterfly top and bottom inputs.
REQ-009 tw_addr  output  ADDR_WIDTH  twiddle ROM address_line; drives w_r/w_i lookup.
REQ-010 stage  output  clog2(S)+1  current stage index 0..S-1.
REQ-011 wr_en  output  1  write-back strobe for butterfly results.
REQ-012 wr_addr_a, wr_addr_b  output  ADDR_WIDTH  write-back addresses paired with wr_en.
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; only one state is occupied at a time.
REQ-016 IDLE: start=1 -> RUN next cycle with stage=0, butterfly index k=0; otherwise stay.
REQ-017 RUN: bf_valid=1; butterfly accepted when bf_valid&&bf_ready; k increments only on acceptance; bf_ready=0 holds all read/twiddle outputs stable.
REQ-018 Address generation for stage s, index k (0..N/2-1): span=2**s; pos=k mod span; grp=k>>s; rd_addr_a=grp*2*span+pos; rd_addr_b=rd_addr_a+span; tw_addr=pos<<(S-1-s); all unsigned, no wrap possible.
REQ-019 Acceptance of k=N/2-1 -> DRAIN next cycle, bf_valid=0.
REQ-020 DRAIN lasts exactly PIPE_LAT cycles; then RUN with stage+1, k=0 if stage<S-1, else DONE.
REQ-021 Write-back pipeline: each acceptance produces wr_en=1 exactly PIPE_LAT cycles later carrying that butterfly's rd_addr_a/rd_addr_b as wr_addr_a/wr_addr_b; independent of bf_ready; no acceptance dropped or duplicated.
REQ-022 Last write of each stage lands in the final DRAIN cycle, so no stage s+1 read precedes a stage s write.
REQ-023 DONE: done=1, busy=0 for one cycle -> IDLE.
REQ-024 start while not in IDLE ignored; start in the DONE cycle ignored.
REQ-025 With bf_ready held 1: busy for S*(N/2+PIPE_LAT) cycles; done in the following cycle.
REQ-026 Input data presumed pre-stored in bit-reversed order (DIT); bit reversal is outside this block.

Reset
REQ-027 rst=1 at any edge, including mid-RUN/DRAIN: next state IDLE; stage, k, drain counter, write-back pipeline cleared.
REQ-028 Reset values: bf_valid=0, wr_en=0, busy=0, done=0, stage=0, all address outputs 0; no wr_en emitted for butterflies in flight at reset.
REQ-029 rst has priority over start in the same cycle.

Verification
REQ-030 N=16, PIPE_LAT=2, bf_ready=1, start at cycle 0 -> busy cycles 1..40, done only at cycle 41, exactly 32 wr_en pulses.
REQ-031 Address check N=16: (s0,k0)->a=0,b=1,tw=0; (s1,k1)->a=1,b=3,tw=4; (s2,k5)->a=9,b=13,tw=2; (s3,k3)->a=3,b=11,tw=3.
REQ-032 bf_ready random 50% -> outputs stable while stalled; each wr_en exactly 2 cycles after its acceptance with matching addresses; every address 0..15 written once per stage.
REQ-033 rst asserted at stage 2 k=4 -> next cycle all outputs 0, state IDLE, no later wr_en; new start runs full 40-cycle sequence.
REQ-034 start pulses during RUN and in the DONE cycle -> ignored; single done pulse, IDLE after.
REQ-035 PIPE_LAT=1 and PIPE_LAT=8 -> DRAIN length matches; busy = 4*(8+PIPE_LAT) cycles.
